// File: rtl/fp_pkg.sv
// Shared fixed-point definitions for the raycaster datapath.
// Holds the default operand format, the saturation limits of each
// supported width, and the requester tag type used by the shared
// multiplier arbiter.
package fp_pkg;

    localparam int unsigned FP_WIDTH      = 16;
    localparam int unsigned FP_FRAC_WIDTH = 8;
    localparam int unsigned FP_NUM_REQ    = 4;

    // Saturation limits for the supported widths (16/8, 24/12, 32/16)
    localparam logic [15:0] SAT_MAX_16 = 16'h7FFF;
    localparam logic [15:0] SAT_MIN_16 = 16'h8000;
    localparam logic [23:0] SAT_MAX_24 = 24'h7F_FFFF;
    localparam logic [23:0] SAT_MIN_24 = 24'h80_0000;
    localparam logic [31:0] SAT_MAX_32 = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN_32 = 32'h8000_0000;

    // Tag width for n requesters; a single requester still needs one bit
    function automatic int unsigned tag_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    localparam int unsigned TAG_W = tag_width(FP_NUM_REQ);
    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/multiply.sv
// Saturating signed fixed-point multiplier (purely combinational).
// Ports:
//   a, b      : signed fixed-point operands (WIDTH bits, FRAC_WIDTH fractional)
//   prod_c    : truncated product, clipped to the representable range
//   ovrflw_c  : 1 when prod_c was clipped
module multiply
    import fp_pkg::*;
#(
    parameter int unsigned WIDTH      = FP_WIDTH,
    parameter int unsigned FRAC_WIDTH = FP_FRAC_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] prod_c,
    output logic             ovrflw_c
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned TOP  = WIDTH + FRAC_WIDTH - 1;
    localparam int unsigned HI_W = PW - TOP;

    logic [PW-1:0]         a_ext;
    logic [PW-1:0]         b_ext;
    logic [PW-1:0]         full;
    logic [HI_W-1:0]       hi;
    logic [FRAC_WIDTH-1:0] unused_frac;

    // Low 2*WIDTH bits of the product of sign-extended operands are the
    // exact two's-complement signed product.
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign full  = a_ext * b_ext;

    // Result fits only if every bit from the kept MSB upward is a sign copy
    assign hi          = full[PW-1:TOP];
    assign unused_frac = full[FRAC_WIDTH-1:0];

    always_comb begin
        ovrflw_c = !((hi == '0) || (hi == '1));
        prod_c   = full[TOP:FRAC_WIDTH];
        if (ovrflw_c) begin
            prod_c = full[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter time-sharing one saturating fixed-point multiplier
// among NUM_REQ requesters. Two register stages: operands (stage 1) and
// product (stage 2); a grant in cycle k responds in cycle k+2.
// Ports:
//   clk_in, rst_in     : clock, synchronous active-high reset
//   req_valid_in       : per-requester request valid
//   req_ready_out      : one-hot grant (accept = valid & ready)
//   req_arg1_in/2_in   : packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid_out     : one-hot, one-cycle response pulse
//   resp_prod_out      : saturated product (holds when no response)
//   resp_ovrflw_out    : saturation flag of the response
//   busy_out           : any stage valid or any request outstanding
// Optional (MULT_SHARE_ARB_STATS_EN defined):
//   ovrflw_count_out   : saturating count of overflowing responses
//   grant_count_out    : saturating per-requester acceptance counts, 16b each
module mult_share_arb
    import fp_pkg::*;
#(
    parameter int unsigned WIDTH      = FP_WIDTH,
    parameter int unsigned FRAC_WIDTH = FP_FRAC_WIDTH,
    parameter int unsigned NUM_REQ    = FP_NUM_REQ
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    input  logic [NUM_REQ*WIDTH-1:0] req_arg1_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_arg2_in,
    output logic [NUM_REQ-1:0]       resp_valid_out,
    output logic [WIDTH-1:0]         resp_prod_out,
    output logic                     resp_ovrflw_out,
    output logic                     busy_out
`ifdef MULT_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]              ovrflw_count_out,
    output logic [NUM_REQ*16-1:0]    grant_count_out
`endif
);

    localparam int unsigned TW = tag_width(NUM_REQ);

    logic [TW-1:0]      rr_ptr;
    logic [TW-1:0]      grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] outstanding;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] accept_vec;
    logic [NUM_REQ-1:0] resp_vec;

    logic               s1_valid;
    logic [TW-1:0]      s1_tag;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic               s2_valid;
    logic [TW-1:0]      s2_tag;

    logic [WIDTH-1:0]   mul_prod;
    logic               mul_ovrflw;

    // (base + off) mod NUM_REQ for base, off < NUM_REQ
    function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] base,
                                               input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return TW'(sum);
    endfunction

    // One in-flight operation per requester
    assign eligible = req_valid_in & ~outstanding;

    // First eligible requester at or after the round-robin pointer
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            if (!grant_any && eligible[wrap_add(rr_ptr, off)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_add(rr_ptr, off);
            end
        end
    end

    // Reset suppresses grants and responses in the reset cycle itself
    assign accept_vec     = (grant_any && !rst_in) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign req_ready_out  = accept_vec;
    assign resp_vec       = s2_valid ? (NUM_REQ'(1) << s2_tag) : '0;
    assign resp_valid_out = rst_in ? '0 : resp_vec;
    assign busy_out       = !rst_in && (s1_valid || s2_valid || (|outstanding));

    multiply #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_multiply (
        .a        (s1_a),
        .b        (s1_b),
        .prod_c   (mul_prod),
        .ovrflw_c (mul_ovrflw)
    );

    // Arbitration state and the two pipeline stages
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr          <= '0;
            outstanding     <= '0;
            s1_valid        <= 1'b0;
            s1_tag          <= '0;
            s1_a            <= '0;
            s1_b            <= '0;
            s2_valid        <= 1'b0;
            s2_tag          <= '0;
            resp_prod_out   <= '0;
            resp_ovrflw_out <= 1'b0;
        end else begin
            outstanding <= (outstanding & ~resp_vec) | accept_vec;
            s1_valid    <= grant_any;
            if (grant_any) begin
                rr_ptr <= wrap_add(grant_idx, 1);
                s1_tag <= grant_idx;
                s1_a   <= req_arg1_in[32'(grant_idx)*WIDTH +: WIDTH];
                s1_b   <= req_arg2_in[32'(grant_idx)*WIDTH +: WIDTH];
            end
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            // Product bus holds its last value between responses
            if (s1_valid) begin
                resp_prod_out   <= mul_prod;
                resp_ovrflw_out <= mul_ovrflw;
            end
        end
    end

`ifdef MULT_SHARE_ARB_STATS_EN
    // Saturating overflow and per-requester grant counters
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ovrflw_count_out <= '0;
            grant_count_out  <= '0;
        end else begin
            if (s2_valid && resp_ovrflw_out && (ovrflw_count_out != 16'hFFFF)) begin
                ovrflw_count_out <= ovrflw_count_out + 16'd1;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (accept_vec[i] && (grant_count_out[i*16 +: 16] != 16'hFFFF)) begin
                    grant_count_out[i*16 +: 16] <= grant_count_out[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter that time-shares one saturating fixed-point multiplier among `NUM_REQ` requesters in the raycaster datapath, such as the per-column ray-step and distance-correction units. Each requester issues operand pairs over a valid/ready handshake. The block registers the operands, runs them through the `multiply` datapath, registers the result, and returns it tagged to the originating requester. Sustained throughput is one product per cycle, with a fixed 2-cycle latency.

## Interface
- `WIDTH`, 16, operand/product width, signed fixed point
- `FRAC_WIDTH`, 8, fractional bits; supported pairs are 16/8, 24/12, 32/16
- `NUM_REQ`, 4, number of requesters, ≥1
- `clk_in`  in  1  single clock; all state on rising edge
- `rst_in`  in  1  synchronous, active-high reset
- `req_valid_in`  in  NUM_REQ  request valid, one bit per requester
- `req_ready_out`  out  NUM_REQ  one-hot grant; a request is accepted when valid&ready
- `req_arg1_in`  in  NUM_REQ*WIDTH  packed operand A; requester i occupies slice [i*WIDTH +: WIDTH]
- `req_arg2_in`  in  NUM_REQ*WIDTH  packed operand B, same packing
- `resp_valid_out`  out  NUM_REQ  one-hot, one-cycle response pulse
- `resp_prod_out`  out  WIDTH  saturated product, shared bus
- `resp_ovrflw_out`  out  1  saturation flag for current response
- `busy_out`  out  1  any stage valid or any request outstanding

## Operation
- Per-requester `outstanding[i]`:
  - set on acceptance;
  - cleared at the clock edge ending the cycle in which `resp_valid_out[i]`=1.
- Eligible set = `req_valid_in & ~outstanding`. This allows at most one in-flight operation per requester.
- Grant: the first eligible index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready_out` is combinational from `req_valid_in`. It is never asserted for a non-valid requester.
  - No eligible requester: `req_ready_out`=0 and `rr_ptr` holds.
- On acceptance of index g:
  - `rr_ptr` ← (g+1) mod NUM_REQ;
  - stage 1 captures valid=1, tag=g, and the arg1/arg2 slices.
- Stage 2 captures s1_valid, s1_tag, and the `multiply` outputs computed from the stage-1 operands.
- Arithmetic is identical to `multiply`:
  - full 2·WIDTH signed product;
  - keep bits [WIDTH+FRAC_WIDTH-1:FRAC_WIDTH] (truncation);
  - clip to max/min (0x7FFF/0x8000 for 16/8) with ovrflw=1.
- Response outputs:
  - `resp_valid_out` = s2_valid ? onehot(s2_tag) : 0;
  - `resp_prod_out` and `resp_ovrflw_out` are driven from stage 2 and hold their last value when invalid.
- Responses have no backpressure. Requesters must sample in the pulse cycle.
- A requester may drop `req_valid_in` without being granted. Operands need only be stable in the accept cycle.

## Timing
- Reset (synchronous) clears:
  - rr_ptr=0, outstanding=0, s1_valid=0, s2_valid=0;
  - all outputs 0: `req_ready_out`, `resp_valid_out`, `resp_prod_out`, `resp_ovrflw_out`, `busy_out`.
- Latency: accepted in cycle k → `resp_valid_out` asserted in cycle k+2.
- Throughput: one grant per cycle across requesters. Per requester, one grant per 3 cycles at most, with the earliest reissue at k+3.
- `req_ready_out[i]`=0 in every cycle where `resp_valid_out[i]`=1.
- Reset asserted mid-operation: in-flight operations are discarded, no response is produced for them, and `req_ready_out` is 0 during the reset cycle.
- Reset has priority over acceptance in the same cycle.
- NUM_REQ=1: pointer is constant 0; behaviour is otherwise identical.

## Configuration
- `MULT_SHARE_ARB_STATS_EN` defined:
  - adds output `ovrflw_count_out` (16 bits), a saturating count (holds at 0xFFFF) of responses with ovrflw=1;
  - adds output `grant_count_out` (NUM_REQ*16 bits), saturating per-requester acceptance counts;
  - all counters clear on reset.
- Undefined: these ports and counters do not exist. Functional behaviour is otherwise identical.

## Structure
- Shared package `fp_pkg` holds:
  - the default WIDTH/FRAC_WIDTH localparams;
  - max/min saturation constants per supported width;
  - a `tag_t` typedef sized to $clog2(NUM_REQ), minimum 1 bit.
- One sub-module: an instance of the existing `multiply` between stage 1 and stage 2. The arbitration logic is inline.

## Test plan
- Req 0 only, 0x0180 × 0x0200 (1.5×2.0) accepted in cycle 1 → `resp_valid_out`=0001 in cycle 3, prod=0x0300, ovrflw=0.
- Req 2, 0x7000 × 0x0400 → prod=0x7FFF, ovrflw=1; 0x9000 × 0x0400 → prod=0x8000, ovrflw=1.
- All four valid from the first post-reset cycle → grants 0,1,2,3 in consecutive cycles, then 0 again 4 cycles later; responses one per cycle in order 0,1,2,3.
- Req 1 and req 3 held valid continuously → grants alternate 1,3,1,3 with no starvation. Each requester's `req_ready_out` is low during its own response-pulse cycle.
- Reset asserted the cycle after req 0 is accepted → no `resp_valid_out` pulse ever appears for it; rr_ptr=0, `busy_out`=0 next cycle.
- With `MULT_SHARE_ARB_STATS_EN`: 3 overflowing and 2 normal requests → `ovrflw_count_out`=3; `grant_count_out` matches issued counts.
